// File: rtl/draw_pkg.sv
// Shared types and constants for the square-plot control path.
package draw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        LOAD_Y,
        CALC_X,
        CALC_Y,
        PLOT,
        DONE
    } draw_state_t;

    localparam int SIDE_LOG2_DEFAULT = 2;
    localparam int INC_W             = 3;

endpackage

// File: rtl/rise_detect.sv
// Single-strobe rising-edge detector; the delay register's reset value
// decides whether an input already high at reset counts as a rise.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_in,
    output logic o_rise
);

    logic r_q;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of process order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_q <= RESET_VAL;
        else         r_q <= i_in;
    end

    assign o_rise = i_in & ~r_q;

endmodule

// File: rtl/draw_control.sv
// Control FSM for the square-plot datapath: latches x/y on user strobes and
// walks a pixel counter in raster order, one plot every three cycles.
module draw_control
    import draw_pkg::*;
#(
    parameter int SIDE_LOG2 = SIDE_LOG2_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_x,
    input  logic             go,
    output logic             ld_rxin,
    output logic             ld_ryin,
    output logic             ld_rxout,
    output logic             ld_ryout,
    output logic             selxy,
    output logic [INC_W-1:0] inc,
    output logic             plot,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = 2 * SIDE_LOG2;

    draw_state_t      r_state;
    draw_state_t      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load_x_rise;
    logic             w_go_rise;
    logic             w_cnt_last;

    rise_detect #(.RESET_VAL(1'b1)) u_load_x_rise (
        .clk    (clk),
        .resetn (resetn),
        .i_in   (load_x),
        .o_rise (w_load_x_rise)
    );

    rise_detect #(.RESET_VAL(1'b1)) u_go_rise (
        .clk    (clk),
        .resetn (resetn),
        .i_in   (go),
        .o_rise (w_go_rise)
    );

    assign w_cnt_last = &r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    // Counter is only cleared on a new draw; the last pixel leaves it at all ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_state == LOAD_Y) begin
            r_cnt <= '0;
        end else if (r_state == PLOT && !w_cnt_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path through the block leaves a value held and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_go_rise)          w_next_state = LOAD_Y;
                else if (w_load_x_rise) w_next_state = LOAD_X;
            end
            LOAD_X:  w_next_state = IDLE;
            LOAD_Y:  w_next_state = CALC_X;
            CALC_X:  w_next_state = CALC_Y;
            CALC_Y:  w_next_state = PLOT;
            PLOT:    w_next_state = w_cnt_last ? DONE : CALC_X;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Moore decode: strobes while busy never reach the outputs.
    always_comb begin
        ld_rxin  = 1'b0;
        ld_ryin  = 1'b0;
        ld_rxout = 1'b0;
        ld_ryout = 1'b0;
        selxy    = 1'b0;
        inc      = '0;
        plot     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            LOAD_X: ld_rxin = 1'b1;
            LOAD_Y: begin
                ld_ryin = 1'b1;
                busy    = 1'b1;
            end
            CALC_X: begin
                ld_rxout = 1'b1;
                inc      = INC_W'(r_cnt[SIDE_LOG2-1:0]);
                busy     = 1'b1;
            end
            CALC_Y: begin
                ld_ryout = 1'b1;
                selxy    = 1'b1;
                inc      = INC_W'(r_cnt[CNT_W-1:SIDE_LOG2]);
                busy     = 1'b1;
            end
            PLOT: begin
                plot = 1'b1;
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_draw_control.sv
// Scoreboard bench for draw_control: expected strobe/pixel events are queued
// with their edge numbers when stimulus is driven and retired by a monitor.
module tb_draw_control;
    import draw_pkg::*;

    localparam int SIDE   = 2;
    localparam int SIDE_N = 1 << SIDE;
    localparam int N      = SIDE_N * SIDE_N;

    typedef struct {
        int cyc;
        int x;
        int y;
    } pix_t;

    logic             clk = 1'b0;
    logic             resetn;
    logic             load_x;
    logic             go;
    logic             ld_rxin, ld_ryin, ld_rxout, ld_ryout, selxy;
    logic [INC_W-1:0] inc;
    logic             plot, busy, done;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cur_x = -1;
    int   cur_y = -1;
    int   rxin_q[$];
    int   ryin_q[$];
    int   done_q[$];
    pix_t pix_q[$];

    draw_control #(.SIDE_LOG2(SIDE)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .load_x   (load_x),
        .go       (go),
        .ld_rxin  (ld_rxin),
        .ld_ryin  (ld_ryin),
        .ld_rxout (ld_rxout),
        .ld_ryout (ld_ryout),
        .selxy    (selxy),
        .inc      (inc),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: every asserted strobe must match the head of its queue.
    always @(negedge clk) begin
        pix_t p;
        if (ld_rxin) begin
            if (rxin_q.size() == 0) check("ld_rxin_unexpected", cyc, -1);
            else                    check("ld_rxin_edge", cyc, rxin_q.pop_front());
        end
        if (ld_ryin) begin
            if (ryin_q.size() == 0) check("ld_ryin_unexpected", cyc, -1);
            else                    check("ld_ryin_edge", cyc, ryin_q.pop_front());
        end
        if (done) begin
            check("done_busy", int'(busy), 1);
            if (done_q.size() == 0) check("done_unexpected", cyc, -1);
            else                    check("done_edge", cyc, done_q.pop_front());
        end
        if (ld_rxout) begin
            cur_x = int'(inc);
            check("calc_x_selxy", int'(selxy), 0);
        end
        if (ld_ryout) begin
            cur_y = int'(inc);
            check("calc_y_selxy", int'(selxy), 1);
        end
        if (!ld_rxout && !ld_ryout)
            check("sel_inc_idle", int'({selxy, inc}), 0);
        if (plot) begin
            check("plot_no_ldout", int'({ld_rxout, ld_ryout}), 0);
            check("plot_busy", int'(busy), 1);
            if (pix_q.size() == 0) begin
                check("plot_unexpected", cyc, -1);
            end else begin
                p = pix_q.pop_front();
                check("plot_edge", cyc, p.cyc);
                check("plot_x", cur_x, p.x);
                check("plot_y", cur_y, p.y);
            end
        end
    end

    // Call at a negedge; the go rise is sampled at the next posedge (edge k).
    task automatic start_draw(output int k);
        go = 1'b1;
        k  = cyc + 1;
        ryin_q.push_back(k);
        for (int i = 0; i < N; i++) begin
            pix_t p;
            p.cyc = k + 3 + 3 * i;
            p.x   = i % SIDE_N;
            p.y   = i / SIDE_N;
            pix_q.push_back(p);
        end
        done_q.push_back(k + 1 + 3 * N);
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_drained(input string tag, input int budget);
        int n = 0;
        while ((pix_q.size() != 0 || done_q.size() != 0 || ryin_q.size() != 0 ||
                rxin_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, pix_q.size() + done_q.size() + ryin_q.size() + rxin_q.size(), 0);
    endtask

    task automatic wait_edge(input string tag, input int target);
        int n = 0;
        while (cyc != target && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, cyc, target);
    endtask

    initial begin
        int k;

        resetn = 1'b0;
        go     = 1'b1;
        load_x = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({ld_rxin, ld_ryin, ld_rxout, ld_ryout, selxy, inc, plot, busy, done}), 0);

        // go already high when reset releases: must not start a draw.
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        check("go_high_at_reset_busy", int'(busy), 0);
        go = 1'b0;
        @(negedge clk);
        start_draw(k);
        wait_drained("draw1_complete", 200);
        repeat (2) @(negedge clk);
        check("idle_after_draw1", int'(busy), 0);

        // Single load_x pulse, then a long hold that must give one pulse only.
        load_x = 1'b1;
        rxin_q.push_back(cyc + 1);
        @(negedge clk);
        load_x = 1'b0;
        repeat (3) @(negedge clk);
        load_x = 1'b1;
        rxin_q.push_back(cyc + 1);
        repeat (10) @(negedge clk);
        load_x = 1'b0;
        wait_drained("load_x_complete", 20);
        repeat (2) @(negedge clk);

        // Simultaneous rises: go wins. A go rise mid-draw changes nothing.
        load_x = 1'b1;
        start_draw(k);
        load_x = 1'b0;
        repeat (10) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        // Rise sampled at the edge leaving DONE is dropped.
        wait_edge("reach_done_edge", k + 1 + 3 * N);
        check("in_done_state", int'(done), 1);
        go = 1'b1;
        repeat (4) @(negedge clk);
        check("done_rise_ignored", int'(busy), 0);
        go = 1'b0;
        wait_drained("draw2_complete", 20);
        repeat (2) @(negedge clk);

        // Asynchronous reset during the 5th plot, then a clean restart.
        start_draw(k);
        wait_edge("reach_fifth_plot", k + 3 + 3 * 4);
        check("fifth_plot_high", int'(plot), 1);
        #2;
        resetn = 1'b0;
        pix_q.delete();
        done_q.delete();
        #1;
        check("async_rst_plot", int'(plot), 0);
        check("async_rst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("no_draw_after_rst", int'(busy), 0);
        start_draw(k);
        wait_drained("draw3_complete", 200);
        repeat (5) @(negedge clk);
        check("final_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
